dl_uart_rx: RTL and testbench

- 8N1 UART receiver for the delay-line platform. It takes command bytes from the MCU on rxd, the reverse path of the platform's UART transmit link.
- Runs on the 10 MHz platform clock.
- Delivers each received byte through a valid/ready holding register to downstream command logic.
- Flags framing errors and overruns.

---
 rtl/dl_uart_rx_pkg.sv | 19 +
 rtl/dl_sync2.sv | 24 ++
 rtl/dl_uart_rx.sv | 193 +++++++++++++++++++
 tb/tb_dl_uart_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_uart_rx_pkg.sv
// Shared definitions for the delay-line UART receive path: frame width,
// platform clock/baud and the receiver FSM state enum.
package dl_uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned DL_CLK_HZ       = 10000000;
  localparam int unsigned DL_UART_BAUD    = 115200;
  localparam int unsigned DL_CLKS_PER_BIT = DL_CLK_HZ / DL_UART_BAUD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_rx_state_e;

endpackage

// File: rtl/dl_sync2.sv
// Generic two-flop synchronizer with configurable reset value; used for
// rxd here and reusable for the tdc_start / tdc_stop inputs.
module dl_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dl_uart_rx.sv
// 8N1 UART receiver with valid/ready holding register, framing and overrun flags.
// Define DL_UART_RX_PARITY_EN for 8E1 framing with parity checking.
module dl_uart_rx
  import dl_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DL_CLKS_PER_BIT
) (
  input  logic                   clk10m,
  input  logic                   rst,
  input  logic                   rxd,
  output logic [UART_DATA_W-1:0] o_rx_byte,
  output logic                   o_rx_valid,
  input  logic                   i_rx_ready,
  output logic                   o_rx_active,
  output logic                   o_frame_err,
  output logic                   o_overrun,
  output logic                   o_parity_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  // START spends CLKS_PER_BIT/2-1 cycles; the sample is taken on the last one
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic                   rx_s;
  logic                   rx_d;
  logic                   rx_fall;
  uart_rx_state_e         state;
  uart_rx_state_e         state_n;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                   cnt_clr;
  logic                   cnt_inc;
  logic                   shift_en;
  logic                   stop_good;
  logic                   stop_bad;
  logic                   deliver;

  dl_sync2 #(.RST_VAL(1'b1)) u_sync_rxd (
    .clk (clk10m),
    .rst (rst),
    .d   (rxd),
    .q   (rx_s)
  );

  always_ff @(posedge clk10m or posedge rst) begin
    if (rst) rx_d <= 1'b1;
    else     rx_d <= rx_s;
  end

  assign rx_fall = rx_d & ~rx_s;

`ifdef DL_UART_RX_PARITY_EN
  logic par_en;
  logic par_bit;
  logic par_ok;

  always_ff @(posedge clk10m or posedge rst) begin
    if (rst)         par_bit <= 1'b0;
    else if (par_en) par_bit <= rx_s;
  end

  assign par_ok  = (par_bit == ^shreg);
  assign deliver = stop_good & par_ok;

  always_ff @(posedge clk10m or posedge rst) begin
    if (rst) o_parity_err <= 1'b0;
    else     o_parity_err <= stop_good & ~par_ok;
  end
`else
  assign deliver      = stop_good;
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge clk10m or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    shift_en  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
`ifdef DL_UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (rx_fall) begin
          state_n = ST_START;
          cnt_clr = 1'b1;
        end
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_clr = 1'b1;
          state_n = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef DL_UART_RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
`ifdef DL_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          par_en  = 1'b1;
          state_n = ST_STOP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            stop_good = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_n   = ST_WAIT_IDLE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk10m or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (shift_en) begin
        shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // A new byte may replace the held one only when it is being accepted this cycle
  always_ff @(posedge clk10m or posedge rst) begin
    if (rst) begin
      o_rx_byte   <= '0;
      o_rx_valid  <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_overrun   <= 1'b0;
      o_frame_err <= stop_bad;
      if (deliver) begin
        if (!o_rx_valid || i_rx_ready) begin
          o_rx_byte  <= shreg;
          o_rx_valid <= 1'b1;
        end else begin
          o_overrun  <= 1'b1;
        end
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_active = (state != ST_IDLE);

endmodule

// File: tb/tb_dl_uart_rx.sv
// Self-checking bench for dl_uart_rx: scenario tasks plus randomized frames
// checked against a queue-based model of the serial protocol.
`timescale 1ns/1ps
module tb_dl_uart_rx;

  localparam int unsigned CPB = 86;
`ifdef DL_UART_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  // valid expected about (FRAME_BITS-0.5) bit times after the start edge
  localparam int unsigned LAT_NOM = ((2 * FRAME_BITS - 1) * CPB) / 2;

  logic       clk10m = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       i_rx_ready = 1'b0;
  logic [7:0] o_rx_byte;
  logic       o_rx_valid;
  logic       o_rx_active;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_parity_err;

  dl_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk10m       (clk10m),
    .rst          (rst),
    .rxd          (rxd),
    .o_rx_byte    (o_rx_byte),
    .o_rx_valid   (o_rx_valid),
    .i_rx_ready   (i_rx_ready),
    .o_rx_active  (o_rx_active),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_parity_err (o_parity_err)
  );

  always #50 clk10m = ~clk10m;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  got_q[$];
  int unsigned cyc = 0;
  int unsigned vcyc = 0;
  int unsigned fe_cnt = 0;
  int unsigned ov_cnt = 0;
  int unsigned pe_cnt = 0;
  int unsigned act_cnt = 0;
  int unsigned last_vrise = 0;
  logic        v_prev = 1'b0;

  always @(negedge clk10m) begin
    cyc++;
    if (o_rx_valid && i_rx_ready) got_q.push_back(o_rx_byte);
    if (o_rx_valid) vcyc++;
    if (o_rx_valid && !v_prev) last_vrise = cyc;
    if (o_frame_err) fe_cnt++;
    if (o_overrun) ov_cnt++;
    if (o_parity_err) pe_cnt++;
    if (o_rx_active) act_cnt++;
    v_prev = o_rx_valid;
  end

  initial begin
    repeat (90000) @(posedge clk10m);
    $display("FAIL watchdog: run exceeded %0d cycles", 90000);
    $fatal(1);
  end

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk10m);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef DL_UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_b);
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk10m);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_cycles(4);
    total++; if (o_rx_byte !== 8'h00) begin bad++; $display("FAIL reset_byte: got %h want 00", o_rx_byte); end
    total++; if (o_rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_rx_valid); end
    total++; if (o_rx_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", o_rx_active); end
    total++; if (o_frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", o_frame_err); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", o_overrun); end
    total++; if (o_parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err: got %b want 0", o_parity_err); end
    rst = 1'b0;
    wait_cycles(10);
  endtask

  task automatic test_single;
    int unsigned q0, v0, fe0, ov0, t0, lat;
    q0 = got_q.size(); v0 = vcyc; fe0 = fe_cnt; ov0 = ov_cnt;
    i_rx_ready = 1'b1;
    t0 = cyc;
    send_frame(8'hAA, 1'b1);
    wait_cycles(CPB);
    lat = last_vrise - t0 - 1;
    total++; if (got_q.size() != q0 + 1) begin bad++; $display("FAIL single_count: got %0d want 1", got_q.size() - q0); end
    total++; if (got_q.size() > q0 && got_q[q0] !== 8'hAA) begin bad++; $display("FAIL single_byte: got %h want aa", got_q[q0]); end
    total++; if (vcyc - v0 != 1) begin bad++; $display("FAIL single_valid_cycles: got %0d want 1", vcyc - v0); end
    // +2 on the late side covers the synchronizer and edge-detect stages
    total++; if (lat + 2 < LAT_NOM || lat > LAT_NOM + 4) begin bad++; $display("FAIL single_latency: got %0d want %0d", lat, LAT_NOM); end
    total++; if (fe_cnt != fe0) begin bad++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt - fe0); end
    total++; if (ov_cnt != ov0) begin bad++; $display("FAIL single_overrun: got %0d want 0", ov_cnt - ov0); end
  endtask

  task automatic test_false_start;
    int unsigned q0, a0, fe0;
    q0 = got_q.size(); a0 = act_cnt; fe0 = fe_cnt;
    rxd = 1'b0;
    wait_cycles(20);
    rxd = 1'b1;
    wait_cycles(100);
    total++; if (act_cnt - a0 != CPB / 2 - 1) begin bad++; $display("FAIL false_start_active: got %0d want %0d", act_cnt - a0, CPB / 2 - 1); end
    total++; if (got_q.size() != q0) begin bad++; $display("FAIL false_start_valid: got %0d want 0", got_q.size() - q0); end
    total++; if (fe_cnt != fe0) begin bad++; $display("FAIL false_start_frame_err: got %0d want 0", fe_cnt - fe0); end
    total++; if (o_rx_active !== 1'b0) begin bad++; $display("FAIL false_start_idle: got %b want 0", o_rx_active); end
  endtask

  task automatic test_frame_err;
    int unsigned v0, fe0, a1;
    v0 = vcyc; fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    wait_cycles(3 * CPB);
    total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt - fe0); end
    total++; if (vcyc != v0) begin bad++; $display("FAIL frame_err_valid: got %0d want 0", vcyc - v0); end
    total++; if (o_rx_active !== 1'b1) begin bad++; $display("FAIL frame_err_hold: got %b want 1", o_rx_active); end
    rxd = 1'b1;
    a1 = act_cnt;
    wait_cycles(CPB);
    total++; if (o_rx_active !== 1'b0) begin bad++; $display("FAIL frame_err_release: got %b want 0", o_rx_active); end
    total++; if (act_cnt - a1 > 4) begin bad++; $display("FAIL frame_err_restart: got %0d want <=4", act_cnt - a1); end
  endtask

  task automatic test_overrun;
    logic [7:0]  frames[2];
    int unsigned q0, ov0;
    frames[0] = 8'h12; frames[1] = 8'h34;
    q0 = got_q.size(); ov0 = ov_cnt;
    i_rx_ready = 1'b0;
    foreach (frames[i]) send_frame(frames[i], 1'b1);
    wait_cycles(CPB);
    total++; if (o_rx_valid !== 1'b1) begin bad++; $display("FAIL overrun_valid_held: got %b want 1", o_rx_valid); end
    total++; if (o_rx_byte !== frames[0]) begin bad++; $display("FAIL overrun_byte: got %h want %h", o_rx_byte, frames[0]); end
    total++; if (ov_cnt - ov0 != 1) begin bad++; $display("FAIL overrun_pulses: got %0d want 1", ov_cnt - ov0); end
    i_rx_ready = 1'b1;
    wait_cycles(1);
    i_rx_ready = 1'b0;
    wait_cycles(5);
    total++; if (got_q.size() != q0 + 1) begin bad++; $display("FAIL overrun_consumed: got %0d want 1", got_q.size() - q0); end
    total++; if (got_q.size() > q0 && got_q[q0] !== frames[0]) begin bad++; $display("FAIL overrun_consumed_byte: got %h want %h", got_q[q0], frames[0]); end
    total++; if (o_rx_valid !== 1'b0) begin bad++; $display("FAIL overrun_valid_drop: got %b want 0", o_rx_valid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  exp_q[$];
    int unsigned q0, v0;
    exp_q = '{8'h00, 8'hFF, 8'h80};
    q0 = got_q.size(); v0 = vcyc;
    i_rx_ready = 1'b1;
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1);
    wait_cycles(CPB);
    total++; if (got_q.size() - q0 != exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size() - q0, exp_q.size()); end
    total++; if (vcyc - v0 != exp_q.size()) begin bad++; $display("FAIL b2b_valid_cycles: got %0d want %0d", vcyc - v0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && q0 + i < got_q.size(); i++) begin
      total++; if (got_q[q0 + i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[q0 + i], exp_q[i]); end
    end
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    wait_cycles(20);
    rst = 1'b1;
    #1;
    total++; if (o_rx_byte !== 8'h00) begin bad++; $display("FAIL midreset_byte: got %h want 00", o_rx_byte); end
    total++; if (o_rx_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", o_rx_valid); end
    total++; if (o_rx_active !== 1'b0) begin bad++; $display("FAIL midreset_active: got %b want 0", o_rx_active); end
    total++; if (o_frame_err !== 1'b0) begin bad++; $display("FAIL midreset_frame_err: got %b want 0", o_frame_err); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL midreset_overrun: got %b want 0", o_overrun); end
    total++; if (o_parity_err !== 1'b0) begin bad++; $display("FAIL midreset_parity_err: got %b want 0", o_parity_err); end
    rxd = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(10);
    q0 = got_q.size();
    send_frame(8'h3C, 1'b1);
    wait_cycles(CPB);
    total++; if (got_q.size() != q0 + 1) begin bad++; $display("FAIL post_reset_count: got %0d want 1", got_q.size() - q0); end
    total++; if (got_q.size() > q0 && got_q[q0] !== 8'h3C) begin bad++; $display("FAIL post_reset_byte: got %h want 3c", got_q[q0]); end
  endtask

  task automatic test_random;
    logic [7:0]  exp_q[$];
    logic [7:0]  d;
    logic        bad_stop;
    int unsigned q0, fe0, ov0, pe0, fe_exp, g;
    q0 = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt; fe_exp = 0;
    i_rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      bad_stop = ($urandom_range(0, 3) == 0);
      send_frame(d, !bad_stop);
      if (bad_stop) begin
        fe_exp++;
        drive_bit(1'b1);
      end else begin
        exp_q.push_back(d);
      end
      rxd = 1'b1;
      g = $urandom_range(0, 15);
      if (g != 0) wait_cycles(g);
    end
    wait_cycles(CPB);
    total++; if (got_q.size() - q0 != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size() - q0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && q0 + i < got_q.size(); i++) begin
      total++; if (got_q[q0 + i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[q0 + i], exp_q[i]); end
    end
    total++; if (fe_cnt - fe0 != fe_exp) begin bad++; $display("FAIL rand_frame_err: got %0d want %0d", fe_cnt - fe0, fe_exp); end
    total++; if (ov_cnt != ov0) begin bad++; $display("FAIL rand_overrun: got %0d want 0", ov_cnt - ov0); end
    total++; if (pe_cnt != pe0) begin bad++; $display("FAIL rand_parity_err: got %0d want 0", pe_cnt - pe0); end
  endtask

`ifdef DL_UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic pbit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(1'b1);
  endtask

  task automatic test_parity;
    int unsigned q0, pe0;
    q0 = got_q.size(); pe0 = pe_cnt;
    i_rx_ready = 1'b1;
    send_frame_par(8'h07, 1'b0);
    wait_cycles(CPB);
    total++; if (pe_cnt - pe0 != 1) begin bad++; $display("FAIL parity_bad_pulse: got %0d want 1", pe_cnt - pe0); end
    total++; if (got_q.size() != q0) begin bad++; $display("FAIL parity_bad_valid: got %0d want 0", got_q.size() - q0); end
    send_frame_par(8'h07, 1'b1);
    wait_cycles(CPB);
    total++; if (pe_cnt - pe0 != 1) begin bad++; $display("FAIL parity_good_pulse: got %0d want 1", pe_cnt - pe0); end
    total++; if (got_q.size() != q0 + 1) begin bad++; $display("FAIL parity_good_count: got %0d want 1", got_q.size() - q0); end
    total++; if (got_q.size() > q0 && got_q[q0] !== 8'h07) begin bad++; $display("FAIL parity_good_byte: got %h want 07", got_q[q0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_random();
`ifdef DL_UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
